// File: rtl/dds_sine_source.sv
// Phase-accumulator DDS sine source with burst/continuous modes on an AXI-Stream master.
// Define DDS_QUARTER_WAVE_EN for a quarter-wave ROM (mirror + sign); output is bit-identical.
module dds_sine_source #(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 8,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [15:0]        amplitude,
  input  logic [31:0]        Ncycles,
  output logic [31:0]        M_AXIS_OUT_tdata,
  output logic               M_AXIS_OUT_tvalid,
  input  logic               M_AXIS_OUT_tready,
  output logic               M_AXIS_OUT_tlast,
  output logic               busy,
  output logic [31:0]        period_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Quadrant-0 magnitudes: round(32767*sin(2*pi*j/256)), j = 0..63 (j = 64 is 32767).
  function automatic logic [15:0] qtab(input logic [5:0] j);
    logic [15:0] v;
    v = '0;
    case (j)
      6'd0:  v = 16'd0;     6'd1:  v = 16'd804;   6'd2:  v = 16'd1608;  6'd3:  v = 16'd2410;
      6'd4:  v = 16'd3212;  6'd5:  v = 16'd4011;  6'd6:  v = 16'd4808;  6'd7:  v = 16'd5602;
      6'd8:  v = 16'd6393;  6'd9:  v = 16'd7179;  6'd10: v = 16'd7962;  6'd11: v = 16'd8739;
      6'd12: v = 16'd9512;  6'd13: v = 16'd10278; 6'd14: v = 16'd11039; 6'd15: v = 16'd11793;
      6'd16: v = 16'd12539; 6'd17: v = 16'd13279; 6'd18: v = 16'd14010; 6'd19: v = 16'd14732;
      6'd20: v = 16'd15446; 6'd21: v = 16'd16151; 6'd22: v = 16'd16846; 6'd23: v = 16'd17530;
      6'd24: v = 16'd18204; 6'd25: v = 16'd18868; 6'd26: v = 16'd19519; 6'd27: v = 16'd20159;
      6'd28: v = 16'd20787; 6'd29: v = 16'd21403; 6'd30: v = 16'd22005; 6'd31: v = 16'd22594;
      6'd32: v = 16'd23170; 6'd33: v = 16'd23731; 6'd34: v = 16'd24279; 6'd35: v = 16'd24811;
      6'd36: v = 16'd25329; 6'd37: v = 16'd25832; 6'd38: v = 16'd26319; 6'd39: v = 16'd26790;
      6'd40: v = 16'd27245; 6'd41: v = 16'd27683; 6'd42: v = 16'd28105; 6'd43: v = 16'd28510;
      6'd44: v = 16'd28898; 6'd45: v = 16'd29268; 6'd46: v = 16'd29621; 6'd47: v = 16'd29956;
      6'd48: v = 16'd30273; 6'd49: v = 16'd30571; 6'd50: v = 16'd30852; 6'd51: v = 16'd31113;
      6'd52: v = 16'd31356; 6'd53: v = 16'd31580; 6'd54: v = 16'd31785; 6'd55: v = 16'd31971;
      6'd56: v = 16'd32137; 6'd57: v = 16'd32285; 6'd58: v = 16'd32412; 6'd59: v = 16'd32521;
      6'd60: v = 16'd32609; 6'd61: v = 16'd32678; 6'd62: v = 16'd32728; 6'd63: v = 16'd32757;
    endcase
    return v;
  endfunction

  // Odd quadrants read the table mirrored; the top index bit selects the negative half-wave.
  function automatic logic [15:0] quarter_mag(input logic [7:0] i);
    logic [6:0] m;
    m = i[6] ? (7'd64 - {1'b0, i[5:0]}) : {1'b0, i[5:0]};
    return m[6] ? 16'd32767 : qtab(m[5:0]);
  endfunction

  function automatic logic [15:0] sine_at(input logic [7:0] i);
    logic [15:0] mag;
    mag = quarter_mag(i);
    return i[7] ? (16'd0 - mag) : mag;
  endfunction

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d, inc_q;
  logic [15:0]          amp_q;
  logic [31:0]          ncyc_q, pcnt_q, pcnt_d;
  logic [LUT_AW-1:0]    idx_q;
  logic [2:0]           vld_pipe_q, last_pipe_q;
  logic [31:0]          tdata_q;
  logic                 adv, issue, issue_last, latch;
  logic [PHASE_W:0]     phase_sum;
  logic [31:0]          pcnt_inc;
  logic signed [DATA_W-1:0] lut_s2, sat_v;
  logic signed [32:0]   prod, shifted;

  localparam logic signed [32:0] SAT_HI = 33'((1 <<< (DATA_W-1)) - 1);
  localparam logic signed [32:0] SAT_LO = -33'(1 <<< (DATA_W-1));

`ifdef DDS_QUARTER_WAVE_EN
  logic [15:0] mag_q;
  logic        neg_q;
  assign lut_s2 = neg_q ? $signed(16'd0 - mag_q) : $signed(mag_q);
`else
  function automatic logic [16*256-1:0] build_rom();
    logic [16*256-1:0] r;
    r = '0;
    for (int i = 0; i < 256; i++) r[i*16 +: 16] = sine_at(8'(i));
    return r;
  endfunction
  localparam logic [16*256-1:0] SINE_ROM = build_rom();
  logic [15:0] rom_q;
  assign lut_s2 = $signed(rom_q);
`endif

  assign adv       = !vld_pipe_q[2] || M_AXIS_OUT_tready;
  assign phase_sum = {1'b0, phase_q} + {1'b0, inc_q};
  assign pcnt_inc  = pcnt_q + 32'd1;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    pcnt_d     = pcnt_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    latch      = 1'b0;
    case (state_q)
      IDLE: if (enable) begin
        latch   = 1'b1;
        phase_d = '0;
        pcnt_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d = DRAIN;
        end else if (adv) begin
          issue   = 1'b1;
          phase_d = phase_sum[PHASE_W-1:0];
          if (phase_sum[PHASE_W]) pcnt_d = pcnt_inc;
          // The carry that completes the Nth period tags this sample as the last one.
          if (phase_sum[PHASE_W] && ncyc_q != '0 && pcnt_inc == ncyc_q) begin
            issue_last = 1'b1;
            state_d    = DRAIN;
          end
        end
      end
      DRAIN: if (vld_pipe_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod    = 33'(lut_s2) * 33'($signed({1'b0, amp_q}));
    shifted = prod >>> 15;
    if (shifted > SAT_HI)      sat_v = SAT_HI[DATA_W-1:0];
    else if (shifted < SAT_LO) sat_v = SAT_LO[DATA_W-1:0];
    else                       sat_v = shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      inc_q       <= '0;
      amp_q       <= '0;
      ncyc_q      <= '0;
      pcnt_q      <= '0;
      idx_q       <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      tdata_q     <= '0;
`ifdef DDS_QUARTER_WAVE_EN
      mag_q       <= '0;
      neg_q       <= 1'b0;
`else
      rom_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pcnt_q  <= pcnt_d;
      if (latch) begin
        inc_q  <= phase_inc;
        amp_q  <= amplitude;
        ncyc_q <= Ncycles;
      end
      if (adv) begin
        idx_q       <= phase_q[PHASE_W-1 -: LUT_AW];
        vld_pipe_q  <= {vld_pipe_q[1:0], issue};
        last_pipe_q <= {last_pipe_q[1:0], issue_last};
`ifdef DDS_QUARTER_WAVE_EN
        mag_q       <= quarter_mag(idx_q);
        neg_q       <= idx_q[LUT_AW-1];
`else
        rom_q       <= SINE_ROM[{idx_q, 4'b0000} +: 16];
`endif
        tdata_q     <= {{(32-DATA_W){sat_v[DATA_W-1]}}, sat_v};
      end
    end
  end

  assign M_AXIS_OUT_tdata  = tdata_q;
  assign M_AXIS_OUT_tvalid = vld_pipe_q[2];
  assign M_AXIS_OUT_tlast  = last_pipe_q[2];
  assign busy              = (state_q != IDLE);
  assign period_count      = pcnt_q;

endmodule

// File: tb/tb_dds_sine_source.sv
// Directed self-checking bench for dds_sine_source: bursts, gain, back-pressure,
// continuous mode, zero step and reset mid-burst against hand-computed samples.
module tb_dds_sine_source;
  logic        clk = 1'b0, rst = 1'b0, enable = 1'b0, tready = 1'b1;
  logic [31:0] phase_inc = '0, Ncycles = '0;
  logic [15:0] amplitude = '0;
  logic [31:0] tdata, pcnt;
  logic        tvalid, tlast, busy;

  int n_chk = 0, n_err = 0;
  int cap_d[$], ref_d[$];
  bit cap_l[$];
  bit seen_last = 1'b0;

  dds_sine_source dut (
    .clk(clk), .rst(rst), .enable(enable), .phase_inc(phase_inc),
    .amplitude(amplitude), .Ncycles(Ncycles),
    .M_AXIS_OUT_tdata(tdata), .M_AXIS_OUT_tvalid(tvalid),
    .M_AXIS_OUT_tready(tready), .M_AXIS_OUT_tlast(tlast),
    .busy(busy), .period_count(pcnt)
  );

  always #5 clk = ~clk;

  // Handshakes are observed mid-cycle; the beat is accepted at the following rising edge.
  always @(negedge clk) begin
    if (rst && tvalid && tready) begin
      cap_d.push_back(int'(tdata));
      cap_l.push_back(tlast);
      if (tlast) seen_last = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_d.delete();
    cap_l.delete();
    seen_last = 1'b0;
  endtask

  function automatic int beat(input int k);
    return (k < cap_d.size()) ? cap_d[k] : 32'h7fff_ffff;
  endfunction

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy; i++) tick();
    chk(tag, busy, 0);
  endtask

  task automatic run_burst(input logic [31:0] inc, input logic [15:0] amp, input logic [31:0] nc,
                           input int stall_at, input logic [31:0] exp_pc);
    int bad, nlast;
    bit stalled;
    logic [31:0] hd;
    logic hl;
    bad = 0; nlast = 0; stalled = 1'b0;
    clear_cap();
    phase_inc = inc; amplitude = amp; Ncycles = nc; tready = 1'b1; enable = 1'b1;
    tick();
    tick();
    tick();
    chk("lat_t2", tvalid, 0);
    tick();
    chk("lat_t3", tvalid, 1);
    for (int i = 0; i < 500; i++) begin
      tick();
      if (seen_last) break;
      if (stall_at >= 0 && !stalled && cap_d.size() == stall_at) begin
        tready = 1'b0;
        hd = tdata;
        hl = tlast;
        repeat (5) begin
          tick();
          if (tdata !== hd || tlast !== hl || tvalid !== 1'b1) bad++;
        end
        chk("stall_hold", bad, 0);
        tready = 1'b1;
        stalled = 1'b1;
      end
    end
    chk("burst_end", seen_last, 1);
    enable = 1'b0;
    chk("tv_after_last", tvalid, 0);
    tick();
    chk("busy_drop", busy, 0);
    chk("pcount", pcnt, exp_pc);
    repeat (4) tick();
    chk("n_beats", cap_d.size(), 64);
    foreach (cap_l[k]) nlast += int'(cap_l[k]);
    chk("n_last", nlast, 1);
    if (cap_l.size() > 0) chk("last_pos", cap_l[cap_l.size()-1], 1);
  endtask

  initial begin
    int diff, nz;
    repeat (3) tick();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pcnt", pcnt, 0);
    rst = 1'b1;
    tick();

    // Unity gain, 32 samples per period, 2 periods.
    run_burst(32'h0800_0000, 16'h8000, 32'd2, -1, 32'd2);
    chk("b0", beat(0), 0);
    chk("b1", beat(1), 6393);
    chk("b4", beat(4), 23170);
    chk("b8", beat(8), 32767);
    chk("b9", beat(9), 32137);
    chk("b12", beat(12), 23170);
    chk("b16", beat(16), 0);
    chk("b20", beat(20), -23170);
    chk("b24", beat(24), -32767);
    chk("b32", beat(32), 0);
    chk("b63", beat(63), -6393);
    ref_d = cap_d;

    run_burst(32'h0800_0000, 16'h4000, 32'd2, -1, 32'd2);
    chk("half_b8", beat(8), 16383);
    chk("half_b24", beat(24), -16384);

    run_burst(32'h0800_0000, 16'hFFFF, 32'd2, -1, 32'd2);
    chk("max_b8", beat(8), 32767);
    chk("max_b24", beat(24), -32768);

    run_burst(32'h0800_0000, 16'h8000, 32'd2, 10, 32'd2);
    diff = 0;
    foreach (ref_d[k]) if (beat(k) != ref_d[k]) diff++;
    chk("stall_stream", diff, 0);

    // Continuous: 99 issues while enable is high in RUN.
    clear_cap();
    phase_inc = 32'h0800_0000; amplitude = 16'h8000; Ncycles = 32'd0; enable = 1'b1;
    repeat (100) tick();
    enable = 1'b0;
    wait_idle("cont_idle");
    chk("cont_beats", cap_d.size(), 99);
    chk("cont_nolast", seen_last, 0);
    chk("cont_pcnt", pcnt, 3);
    chk("cont_b40", beat(40), 32767);

    // Zero step: never reaches a period boundary, only abort ends it.
    clear_cap();
    phase_inc = 32'd0; Ncycles = 32'd1; enable = 1'b1;
    repeat (30) tick();
    chk("zero_busy", busy, 1);
    chk("zero_tvalid", tvalid, 1);
    chk("zero_pcnt", pcnt, 0);
    enable = 1'b0;
    wait_idle("zero_idle");
    nz = 0;
    foreach (cap_d[k]) if (cap_d[k] != 0) nz++;
    chk("zero_data", nz, 0);
    chk("zero_nolast", seen_last, 0);

    // Reset at beat 20 with 16 samples per period, then re-arm from enable.
    clear_cap();
    phase_inc = 32'h1000_0000; Ncycles = 32'd2; enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cap_d.size() >= 20) break;
    end
    chk("pre_rst_pcnt", pcnt, 1);
    rst = 1'b0;
    tick();
    chk("mid_rst_tvalid", tvalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pcnt", pcnt, 0);
    clear_cap();
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cap_d.size() >= 9) break;
    end
    chk("rearm_b0", beat(0), 0);
    chk("rearm_b4", beat(4), 32767);
    enable = 1'b0;
    wait_idle("abort_idle");
    chk("abort_nolast", seen_last, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule
